dff_shift_reg: RTL and testbench
================================

DFF_SHIFT_REG -- requirements
Module: dff_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter RESET_VAL, default '0 (WIDTH bits), value loaded into q by clr.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 pre  input  1  synchronous preset, active-high; sets q to all ones.
REQ-006 en  input  1  operation enable; when 0, q holds regardless of mode.
REQ-007 mode  input  2  operation: 00 hold, 01 shift right (toward bit 0), 10 shift left (toward MSB), 11 parallel load.
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin_r  input  1  serial input entering MSB on shift right.
REQ-010 sin_l  input  1  serial input entering bit 0 on shift left.
REQ-011 q  output  WIDTH  register contents.
REQ-012 qbar  output  WIDTH  bitwise complement of q.
REQ-013 sout_r  output  1  equals q[0].
REQ-014 sout_l  output  1  equals q[WIDTH-1].
REQ-015 shift_cnt  output  $clog2(WIDTH+1)  shifts performed since last load/clr/pre, saturating at WIDTH.
REQ-016 full  output  1  high when shift_cnt == WIDTH.

Function
REQ-017 Update priority per edge: clr > pre > (en=0 hold) > mode.
REQ-018 Shift right: q <= {sin_r, q[WIDTH-1:1]}; shift left: q <= {q[WIDTH-2:0], sin_l}.
REQ-019 Parallel load: q <= d; shift_cnt <= 0.
REQ-020 Each enabled shift increments shift_cnt by 1; at WIDTH it holds (no wrap); shifting continues.
REQ-021 Hold (mode 00 or en=0): q and shift_cnt unchanged.
REQ-022 pre: q <= all ones, shift_cnt <= 0, regardless of en/mode.
REQ-023 qbar, sout_r, sout_l, full are combinational from registered state; latency from edge is zero additional cycles.
REQ-024 qbar SHALL equal ~q at all times after first edge; no X on outputs once clr has been applied.
REQ-025 clr and pre asserted together: clr result only.

Reset
REQ-026 clr high at edge: q <= RESET_VAL, shift_cnt <= 0, full <= 0, qbar <= ~RESET_VAL, sout_r/sout_l follow RESET_VAL.
REQ-027 clr mid-shift-sequence aborts it; next cycle behaves as freshly reset.
REQ-028 State before first clr is undefined; bench SHALL apply clr for at least one edge.

Configuration
REQ-029 Macro SHREG_ROTATE_EN: when defined, input port rot (1 bit) exists; rot=1 makes modes 01/10 rotate (sin_r/sin_l ignored; q[0]->MSB or MSB->q[0]), shift_cnt counts as for shifts.
REQ-030 Without SHREG_ROTATE_EN: no rot port; shifts always take serial inputs.

Structure
REQ-031 Package dff_pkg holds mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD (2-bit).
REQ-032 Sub-module dff_bit: one bit with sync clr/pre/en and next-value input, instantiated WIDTH times; counter logic stays in dff_shift_reg.

Verification (WIDTH=8, RESET_VAL=8'h00)
REQ-033 clr=1 one edge -> q=00, qbar=FF, shift_cnt=0, full=0.
REQ-034 en=1 mode=11 d=A5, then mode=01 sin_r=0 one edge -> q=52, sout_r=0, shift_cnt=1.
REQ-035 load 81, mode=10 sin_l=1 for 8 edges -> q=FF, shift_cnt=8, full=1; 9th shift -> shift_cnt stays 8.
REQ-036 pre=1 with mode=11 d=3C -> q=FF, shift_cnt=0; pre=1 and clr=1 same edge -> q=00.
REQ-037 en=0, mode=01, 4 edges after load 5A -> q=5A, shift_cnt=0.
REQ-038 With SHREG_ROTATE_EN: load 81, rot=1 mode=01 one edge -> q=C0; without macro same stimulus (sin_r=0) -> q=40.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared mode encoding for the dff_shift_reg register slice.
package dff_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    function automatic logic is_shift(input mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/dff_bit.sv
// Single register bit: sync clear to a per-bit reset value, sync preset to 1, enabled load.
module dff_bit (
    input  logic clk,
    input  logic clr,
    input  logic pre,
    input  logic en,
    input  logic rst_val,
    input  logic nxt,
    output logic q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= rst_val;
        else if (pre)
            q <= 1'b1;
        else if (en)
            q <= nxt;
    end

endmodule

// File: rtl/dff_shift_reg.sv
// Universal shift register with saturating shift counter.
// Optional SHREG_ROTATE_EN adds a rot input turning shifts into rotates.
module dff_shift_reg
    import dff_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       pre,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin_r,
    input  logic                       sin_l,
`ifdef SHREG_ROTATE_EN
    input  logic                       rot,
`endif
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qbar,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       full
);

    localparam int unsigned    CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

    mode_e            op;
    logic             rot_sel;
    logic             in_r;
    logic             in_l;
    logic [WIDTH-1:0] nxt;

    assign op = mode_e'(mode);

`ifdef SHREG_ROTATE_EN
    assign rot_sel = rot;
`else
    assign rot_sel = 1'b0;
`endif

    // Rotation just reroutes the opposite end of q into the serial input.
    assign in_r = rot_sel ? q[0]       : sin_r;
    assign in_l = rot_sel ? q[WIDTH-1] : sin_l;

    always_comb begin
        nxt = q;
        case (op)
            MODE_HOLD: nxt = q;
            MODE_SHR:  nxt = {in_r, q[WIDTH-1:1]};
            MODE_SHL:  nxt = {q[WIDTH-2:0], in_l};
            MODE_LOAD: nxt = d;
            default:   nxt = q;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_bit u_bit (
            .clk     (clk),
            .clr     (clr),
            .pre     (pre),
            .en      (en),
            .rst_val (RESET_VAL[i]),
            .nxt     (nxt[i]),
            .q       (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (clr || pre)
            shift_cnt <= '0;
        else if (en) begin
            if (op == MODE_LOAD)
                shift_cnt <= '0;
            else if (is_shift(op) && (shift_cnt != CNT_MAX))
                shift_cnt <= shift_cnt + 1'b1;
        end
    end

    assign qbar   = ~q;
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
    assign full   = (shift_cnt == CNT_MAX);

endmodule

// File: tb/tb_dff_shift_reg.sv
// Scoreboard bench for dff_shift_reg (WIDTH=8, RESET_VAL=8'h00).
module tb_dff_shift_reg;

    logic       clk = 1'b0;
    logic       clr = 1'b0, pre = 1'b0, en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00;
    logic       sin_r = 1'b0, sin_l = 1'b0, rot = 1'b0;
    logic [7:0] q, qbar;
    logic       sout_r, sout_l, full;
    logic [3:0] shift_cnt;

    typedef struct {
        logic [7:0] q;
        logic [3:0] cnt;
        logic       full;
        int         due;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cycle  = 0;
    int   passed = 0;
    int   total  = 0;
    bit   done   = 1'b0;

    dff_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .clr       (clr),
        .pre       (pre),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
`ifdef SHREG_ROTATE_EN
        .rot       (rot),
`endif
        .q         (q),
        .qbar      (qbar),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .shift_cnt (shift_cnt),
        .full      (full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Drive one edge worth of inputs and queue the hand-computed result for after that edge.
    task automatic step(input logic c, input logic p, input logic e, input logic [1:0] m,
                        input logic [7:0] dd, input logic sr, input logic sl, input logic r,
                        input logic [7:0] eq, input logic [3:0] ecnt, input string name);
        exp_t x;
        @(negedge clk);
        clr = c; pre = p; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl; rot = r;
        x.q = eq; x.cnt = ecnt; x.full = (ecnt == 4'd8); x.due = cycle + 1; x.name = name;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                x = sb.pop_front();
                total++;
                if (x.due != cycle)
                    $display("FAIL %s: sample missed (due %0d, now %0d)", x.name, x.due, cycle);
                else if (q !== x.q || qbar !== ~x.q || sout_r !== x.q[0] || sout_l !== x.q[7] ||
                         shift_cnt !== x.cnt || full !== x.full)
                    $display("FAIL %s: got q=%h qbar=%h sr=%b sl=%b cnt=%0d full=%b, want q=%h qbar=%h sr=%b sl=%b cnt=%0d full=%b",
                             x.name, q, qbar, sout_r, sout_l, shift_cnt, full,
                             x.q, ~x.q, x.q[0], x.q[7], x.cnt, x.full);
                else
                    passed++;
            end
        end
    end

    initial begin : stim
        step(1,0,0,2'b00,8'h00,0,0,0, 8'h00,0, "reset");
        step(0,0,1,2'b11,8'hA5,0,0,0, 8'hA5,0, "load_a5");
        step(0,0,1,2'b01,8'h00,0,0,0, 8'h52,1, "shr_a5");
        step(0,0,1,2'b11,8'h81,0,0,0, 8'h81,0, "load_81");
        step(0,0,1,2'b10,8'h00,0,1,0, 8'h03,1, "shl1");
        step(0,0,1,2'b10,8'h00,0,1,0, 8'h07,2, "shl2");
        step(0,0,1,2'b10,8'h00,0,1,0, 8'h0F,3, "shl3");
        step(0,0,1,2'b10,8'h00,0,1,0, 8'h1F,4, "shl4");
        step(0,0,1,2'b10,8'h00,0,1,0, 8'h3F,5, "shl5");
        step(0,0,1,2'b10,8'h00,0,1,0, 8'h7F,6, "shl6");
        step(0,0,1,2'b10,8'h00,0,1,0, 8'hFF,7, "shl7");
        step(0,0,1,2'b10,8'h00,0,1,0, 8'hFF,8, "shl8_full");
        step(0,0,1,2'b10,8'h00,0,0,0, 8'hFE,8, "shl9_sat");
        step(0,1,1,2'b11,8'h3C,0,0,0, 8'hFF,0, "pre_over_load");
        step(1,1,1,2'b11,8'h3C,0,0,0, 8'h00,0, "clr_over_pre");
        step(0,0,1,2'b11,8'h5A,0,0,0, 8'h5A,0, "load_5a");
        for (int i = 0; i < 4; i++)
            step(0,0,0,2'b01,8'h00,1,1,0, 8'h5A,0, "en0_hold");
        step(0,0,1,2'b00,8'hFF,1,1,0, 8'h5A,0, "mode_hold");
        step(0,0,1,2'b01,8'h00,1,0,0, 8'hAD,1, "shr_sin1_a");
        step(0,0,1,2'b01,8'h00,1,0,0, 8'hD6,2, "shr_sin1_b");
        step(1,0,1,2'b01,8'h00,1,0,0, 8'h00,0, "clr_mid_shift");
        step(0,0,1,2'b01,8'h00,1,0,0, 8'h80,1, "shift_after_clr");
        step(0,0,1,2'b11,8'h81,0,0,0, 8'h81,0, "load_81_rot");
`ifdef SHREG_ROTATE_EN
        step(0,0,1,2'b01,8'h00,0,0,1, 8'hC0,1, "rot_right");
        step(0,0,1,2'b10,8'h00,0,0,1, 8'h81,2, "rot_left");
`else
        step(0,0,1,2'b01,8'h00,0,0,1, 8'h40,1, "norot_right");
        step(0,0,1,2'b10,8'h00,0,0,1, 8'h80,2, "norot_left");
`endif
        step(0,1,0,2'b00,8'h00,0,0,0, 8'hFF,0, "pre_en0");
        step(0,0,0,2'b00,8'h00,0,0,0, 8'hFF,0, "idle");
        repeat (4) @(negedge clk);
        total++;
        if (sb.size() != 0)
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
